// File: rtl/change_payout_ctrl_if.sv
// Coin hopper eject handshake: the controller drives req/sel and the hopper answers with ack.
interface change_payout_ctrl_if;
  logic       eject_req;
  logic [1:0] eject_sel;
  logic       eject_ack;

  modport master (output eject_req, output eject_sel, input eject_ack);
  modport slave  (input eject_req, input eject_sel, output eject_ack);
endinterface

// File: rtl/change_payout_ctrl.sv
// Change/refund payout sequencer: greedy hi/mid/lo coin decomposition with per-tube inventory.
// Optional eject-ack timeout with operator-cleared FAULT state: define CHANGE_PAYOUT_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | waiting for start, remaining/short hold last result
// SELECT   | pick largest affordable stocked coin, or finish
// EJECT    | eject_req held until hopper ack
// DONE     | one-cycle done pulse, short valid
// FAULT    | ack timed out, frozen until start clears (timeout build only)
module change_payout_ctrl #(
  parameter int W          = 8,
  parameter int INV_W      = 6,
  parameter int DEN_HI     = 10,
  parameter int DEN_MID    = 5,
  parameter int DEN_LO     = 1,
  parameter int INIT_INV   = 8,
  parameter int LOW_THRESH = 2
`ifdef CHANGE_PAYOUT_TIMEOUT_EN
  , parameter int TIMEOUT  = 64
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  change_payout_ctrl_if.master      ej,
  input  logic                      start_i,
  input  logic [W-1:0]              change_amt_i,
  input  logic                      refill_i,
  input  logic [1:0]                refill_sel_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      short_o,
  output logic [W-1:0]              remaining_o,
  output logic [INV_W-1:0]          inv_hi_o,
  output logic [INV_W-1:0]          inv_mid_o,
  output logic [INV_W-1:0]          inv_lo_o,
  output logic                      low_stock_o
);

  localparam logic [1:0]       SEL_LO   = 2'b01;
  localparam logic [1:0]       SEL_MID  = 2'b10;
  localparam logic [1:0]       SEL_HI   = 2'b11;
  localparam logic [W-1:0]     DHI      = W'(DEN_HI);
  localparam logic [W-1:0]     DMID     = W'(DEN_MID);
  localparam logic [W-1:0]     DLO      = W'(DEN_LO);
  localparam logic [INV_W-1:0] INV_INIT = INV_W'(INIT_INV);
  localparam logic [INV_W-1:0] INV_MAX  = {INV_W{1'b1}};
  localparam logic [INV_W-1:0] LOW_LIM  = INV_W'(LOW_THRESH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_EJECT,
    S_DONE
`ifdef CHANGE_PAYOUT_TIMEOUT_EN
    , S_FAULT
`endif
  } state_t;

  state_t           state_q, state_d;
  logic             req_q, req_d;
  logic [1:0]       sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             short_q, short_d;
  logic [W-1:0]     rem_q, rem_d;
  logic [INV_W-1:0] inv_hi_q, inv_hi_d;
  logic [INV_W-1:0] inv_mid_q, inv_mid_d;
  logic [INV_W-1:0] inv_lo_q, inv_lo_d;
  logic             dec_hi, dec_mid, dec_lo;
  logic [W-1:0]     den_cur;

`ifdef CHANGE_PAYOUT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  // A refill and an eject on the same tube in the same cycle cancel out.
  function automatic logic [INV_W-1:0] inv_next(input logic [INV_W-1:0] cur,
                                                input logic add, input logic sub);
    logic [INV_W-1:0] r;
    r = cur;
    if (add && !sub) begin
      r = (cur == INV_MAX) ? cur : cur + INV_W'(1);
    end else if (sub && !add) begin
      r = cur - INV_W'(1);
    end
    return r;
  endfunction

  always_comb begin
    case (sel_q)
      SEL_HI:  den_cur = DHI;
      SEL_MID: den_cur = DMID;
      default: den_cur = DLO;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    short_d = short_q;
    rem_d   = rem_q;
    dec_hi  = 1'b0;
    dec_mid = 1'b0;
    dec_lo  = 1'b0;
`ifdef CHANGE_PAYOUT_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          rem_d   = change_amt_i;
          busy_d  = 1'b1;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        if (rem_q >= DHI && inv_hi_q != '0) begin
          sel_d   = SEL_HI;
          req_d   = 1'b1;
          state_d = S_EJECT;
        end else if (rem_q >= DMID && inv_mid_q != '0) begin
          sel_d   = SEL_MID;
          req_d   = 1'b1;
          state_d = S_EJECT;
        end else if (rem_q >= DLO && inv_lo_q != '0) begin
          sel_d   = SEL_LO;
          req_d   = 1'b1;
          state_d = S_EJECT;
        end else begin
          done_d  = 1'b1;
          short_d = (rem_q != '0);
          state_d = S_DONE;
        end
`ifdef CHANGE_PAYOUT_TIMEOUT_EN
        tmo_d = TW'(TIMEOUT - 1);
`endif
      end
      S_EJECT: begin
        if (ej.eject_ack) begin
          rem_d   = rem_q - den_cur;
          dec_hi  = (sel_q == SEL_HI);
          dec_mid = (sel_q == SEL_MID);
          dec_lo  = (sel_q == SEL_LO);
          req_d   = 1'b0;
          state_d = S_SELECT;
        end
`ifdef CHANGE_PAYOUT_TIMEOUT_EN
        else if (tmo_q == '0) begin
          req_d   = 1'b0;
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
`endif
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
`ifdef CHANGE_PAYOUT_TIMEOUT_EN
      S_FAULT: begin
        // start here is an operator clear only, not a new payout
        if (start_i) begin
          done_d  = 1'b1;
          short_d = 1'b1;
          state_d = S_DONE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    inv_hi_d  = inv_next(inv_hi_q,  refill_i && refill_sel_i == SEL_HI,  dec_hi);
    inv_mid_d = inv_next(inv_mid_q, refill_i && refill_sel_i == SEL_MID, dec_mid);
    inv_lo_d  = inv_next(inv_lo_q,  refill_i && refill_sel_i == SEL_LO,  dec_lo);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      sel_q     <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      short_q   <= 1'b0;
      rem_q     <= '0;
      inv_hi_q  <= INV_INIT;
      inv_mid_q <= INV_INIT;
      inv_lo_q  <= INV_INIT;
`ifdef CHANGE_PAYOUT_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      short_q   <= short_d;
      rem_q     <= rem_d;
      inv_hi_q  <= inv_hi_d;
      inv_mid_q <= inv_mid_d;
      inv_lo_q  <= inv_lo_d;
`ifdef CHANGE_PAYOUT_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign ej.eject_req = req_q;
  assign ej.eject_sel = sel_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign short_o      = short_q;
  assign remaining_o  = rem_q;
  assign inv_hi_o     = inv_hi_q;
  assign inv_mid_o    = inv_mid_q;
  assign inv_lo_o     = inv_lo_q;
  assign low_stock_o  = (inv_hi_q <= LOW_LIM) || (inv_mid_q <= LOW_LIM) || (inv_lo_q <= LOW_LIM);

endmodule

// File: tb/tb_change_payout_ctrl.sv
// Directed bench for change_payout_ctrl: expected ejects and done results are queued, then
// checked as the hopper model serves the DUT.
module tb_change_payout_ctrl;

  typedef struct packed {
    logic       short_f;
    logic [7:0] rem;
  } done_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] change_amt;
  logic       refill;
  logic [1:0] refill_sel;
  logic       busy, done, short_o;
  logic [7:0] remaining;
  logic [5:0] inv_hi, inv_mid, inv_lo;
  logic       low_stock;

  int errors = 0;
  int checks = 0;

  logic [1:0] exp_sel[$];
  done_t      exp_done[$];

  change_payout_ctrl_if ej ();

  change_payout_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ej           (ej),
    .start_i      (start),
    .change_amt_i (change_amt),
    .refill_i     (refill),
    .refill_sel_i (refill_sel),
    .busy_o       (busy),
    .done_o       (done),
    .short_o      (short_o),
    .remaining_o  (remaining),
    .inv_hi_o     (inv_hi),
    .inv_mid_o    (inv_mid),
    .inv_lo_o     (inv_lo),
    .low_stock_o  (low_stock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] amt, input bit hold_second);
    @(negedge clk);
    start      = 1'b1;
    change_amt = amt;
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    if (hold_second) change_amt = 8'd99;
    else start = 1'b0;
  endtask

  task automatic refill_cycles(input logic [1:0] sel, input int n);
    @(negedge clk);
    refill     = 1'b1;
    refill_sel = sel;
    for (int i = 0; i < n - 1; i++) @(negedge clk);
    @(negedge clk);
    refill     = 1'b0;
    refill_sel = 2'b00;
  endtask

  // Hopper model: acks each eject at once, compares each eject and the final done with the queues.
  task automatic drain(input logic [1:0] ack_refill);
    int         gap;
    bit         fin;
    logic [1:0] es;
    done_t      ed;
    gap = 0;
    fin = 1'b0;
    for (int b = 0; b < 300 && !fin; b++) begin
      @(negedge clk);
      start = 1'b0;
      gap++;
      if (ej.eject_req) begin
        chk("event_gap", gap, 1);
        gap = 0;
        if (exp_sel.size() > 0) es = exp_sel.pop_front();
        else es = 2'b00;
        chk("eject_sel", ej.eject_sel, es);
        ej.eject_ack = 1'b1;
        refill       = (ack_refill != 2'b00);
        refill_sel   = ack_refill;
        @(negedge clk);
        ej.eject_ack = 1'b0;
        refill       = 1'b0;
        refill_sel   = 2'b00;
        chk("eject_req_drop", ej.eject_req, 0);
      end else if (done) begin
        chk("event_gap", gap, 1);
        if (exp_done.size() > 0) ed = exp_done.pop_front();
        else ed = '1;
        chk("done_short", short_o, ed.short_f);
        chk("done_remaining", remaining, ed.rem);
        fin = 1'b1;
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
        chk("remaining_holds", remaining, ed.rem);
      end
    end
    chk("drain_finished", fin, 1);
    chk("sel_queue_empty", exp_sel.size(), 0);
  endtask

  task automatic push_sel(input logic [1:0] s, input int n);
    for (int i = 0; i < n; i++) exp_sel.push_back(s);
  endtask

  task automatic pay(input logic [7:0] amt, input logic sh, input logic [7:0] rem,
                     input logic [1:0] ack_refill, input bit hold_second);
    done_t d;
    d.short_f = sh;
    d.rem     = rem;
    exp_done.push_back(d);
    do_start(amt, hold_second);
    drain(ack_refill);
  endtask

  task automatic chk_inv(input string tag, input logic [5:0] h, input logic [5:0] m,
                         input logic [5:0] l);
    chk({tag, "_inv_hi"}, inv_hi, h);
    chk({tag, "_inv_mid"}, inv_mid, m);
    chk({tag, "_inv_lo"}, inv_lo, l);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit seen;
    int hi_cycles;
    rst_n        = 1'b0;
    start        = 1'b0;
    change_amt   = 8'd0;
    refill       = 1'b0;
    refill_sel   = 2'b00;
    ej.eject_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset values
    chk("rst_eject_req", ej.eject_req, 0);
    chk("rst_eject_sel", ej.eject_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_short", short_o, 0);
    chk("rst_remaining", remaining, 0);
    chk_inv("rst", 8, 8, 8);
    chk("rst_low_stock", low_stock, 0);

    // 17 = 10 + 5 + 1 + 1
    push_sel(2'b11, 1); push_sel(2'b10, 1); push_sel(2'b01, 2);
    pay(8'd17, 1'b0, 8'd0, 2'b00, 1'b0);
    chk_inv("pay17", 7, 7, 6);
    chk("pay17_low_stock", low_stock, 0);

    // zero amount: done two cycles after start
    pay(8'd0, 1'b0, 8'd0, 2'b00, 1'b0);

    // empty the hi tube, then 10 must come out as two mids
    apply_reset();
    chk_inv("rst2", 8, 8, 8);
    push_sel(2'b11, 8);
    pay(8'd80, 1'b0, 8'd0, 2'b00, 1'b0);
    chk("hi_empty_low_stock", low_stock, 1);
    push_sel(2'b10, 2);
    pay(8'd10, 1'b0, 8'd0, 2'b00, 1'b0);
    chk_inv("no_hi", 0, 6, 8);

    // drain mid, bring lo down to 1, then a shortfall
    push_sel(2'b10, 6);
    pay(8'd30, 1'b0, 8'd0, 2'b00, 1'b0);
    push_sel(2'b01, 7);
    pay(8'd7, 1'b0, 8'd0, 2'b00, 1'b0);
    chk_inv("lo_one", 0, 0, 1);
    push_sel(2'b01, 1);
    pay(8'd3, 1'b1, 8'd2, 2'b00, 1'b0);
    chk("short_low_stock", low_stock, 1);
    chk_inv("short", 0, 0, 0);

    // refills: lo x2, a no-op, mid x1
    refill_cycles(2'b01, 2);
    chk("refill_lo", inv_lo, 2);
    refill_cycles(2'b00, 1);
    chk_inv("refill_noop", 0, 0, 2);
    refill_cycles(2'b10, 1);
    chk("refill_mid", inv_mid, 1);

    // refill and ack on the lo tube in the same cycle
    push_sel(2'b01, 1);
    pay(8'd1, 1'b0, 8'd0, 2'b01, 1'b0);
    chk("refill_ack_same_tube", inv_lo, 2);

    // saturation at 63
    refill_cycles(2'b11, 63);
    chk("refill_hi_63", inv_hi, 63);
    refill_cycles(2'b11, 1);
    chk("refill_hi_saturate", inv_hi, 63);

    // second start while busy and a changed change_amt are ignored
    push_sel(2'b11, 2);
    pay(8'd20, 1'b0, 8'd0, 2'b00, 1'b1);
    chk_inv("start_ignored", 61, 1, 2);

    // reset asserted while eject_req is high
    do_start(8'd5, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (ej.eject_req) seen = 1'b1;
    end
    chk("req_before_reset", seen, 1);
    chk("req_sel_mid", ej.eject_sel, 2'b10);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_eject_req", ej.eject_req, 0);
    chk("midrst_eject_sel", ej.eject_sel, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_short", short_o, 0);
    chk("midrst_remaining", remaining, 0);
    chk_inv("midrst", 8, 8, 8);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef CHANGE_PAYOUT_TIMEOUT_EN
    // no ack: eject_req held for 64 cycles, then FAULT until a start clears it
    do_start(8'd5, 1'b0);
    hi_cycles = 0;
    seen      = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (ej.eject_req) hi_cycles++;
      else if (hi_cycles > 0) seen = 1'b1;
    end
    chk("timeout_req_cycles", hi_cycles, 64);
    chk("fault_busy", busy, 1);
    chk("fault_remaining", remaining, 5);
    chk("fault_inv_mid", inv_mid, 8);
    @(negedge clk);
    chk("fault_no_done", done, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("fault_clear_done", done, 1);
    chk("fault_clear_short", short_o, 1);
    @(negedge clk);
    chk("fault_clear_idle", busy, 0);
    chk("fault_clear_no_req", ej.eject_req, 0);
`else
    hi_cycles = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
